// File: rtl/draw_card_mover.sv
// Card sprite overlay for the VGA chain: draws one ROM bitmap in four orientations with
// colour-key transparency, and glides it toward a target one step per frame.
module draw_card_mover #(
   parameter int          CARD_W      = 56,
   parameter int          CARD_H      = 80,
   parameter int          ADDR_W      = 13,
   parameter int          ROM_LATENCY = 1,
   parameter int          STEP        = 4,
   parameter logic [11:0] KEY_RGB     = 12'h0F0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [11:0]       vga_in_hcount_i,
   input  logic [11:0]       vga_in_vcount_i,
   input  logic              vga_in_hsync_i,
   input  logic              vga_in_vsync_i,
   input  logic              vga_in_hblnk_i,
   input  logic              vga_in_vblnk_i,
   input  logic [11:0]       vga_in_rgb_i,
   output logic [11:0]       vga_out_hcount_o,
   output logic [11:0]       vga_out_vcount_o,
   output logic              vga_out_hsync_o,
   output logic              vga_out_vsync_o,
   output logic              vga_out_hblnk_o,
   output logic              vga_out_vblnk_o,
   output logic [11:0]       vga_out_rgb_o,
   input  logic              start_i,
   input  logic [11:0]       x_start_i,
   input  logic [11:0]       y_start_i,
   input  logic [11:0]       x_end_i,
   input  logic [11:0]       y_end_i,
   input  logic [1:0]        angle_i,
   input  logic              clear_i,
   input  logic [11:0]       rgb_pixel_i,
   output logic [ADDR_W-1:0] pixel_addr_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int          RL     = ROM_LATENCY;
   localparam logic [11:0] STEP12 = 12'(STEP);
   localparam logic [12:0] CW13   = 13'(CARD_W);
   localparam logic [12:0] CH13   = 13'(CARD_H);
   localparam logic [ADDR_W-1:0] CWA = ADDR_W'(CARD_W);
   localparam logic [ADDR_W-1:0] CHA = ADDR_W'(CARD_H);

   typedef enum logic [1:0] {IDLE, WAIT_FRAME, MOVE, LANDED} state_t;

   state_t      state_q;
   logic        vb_prev_q, vis_q, busy_q, done_q;
   logic [11:0] st_x_q, st_y_q, tgt_x_q, tgt_y_q, cur_x_q, cur_y_q;
   logic [1:0]  ang_q, cur_ang_q;
   logic        fe;

   assign fe = vga_in_vblnk_i & ~vb_prev_q;

   function automatic logic [11:0] step_to(input logic [11:0] cur, input logic [11:0] tgt);
      if (tgt >= cur) step_to = ((tgt - cur) > STEP12) ? cur + STEP12 : tgt;
      else            step_to = ((cur - tgt) > STEP12) ? cur - STEP12 : tgt;
   endfunction

   // Shadow position/angle/visibility only change at the frame edge so a frame never tears.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         vb_prev_q <= 1'b0;
         vis_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         st_x_q    <= '0;
         st_y_q    <= '0;
         tgt_x_q   <= '0;
         tgt_y_q   <= '0;
         cur_x_q   <= '0;
         cur_y_q   <= '0;
         ang_q     <= '0;
         cur_ang_q <= '0;
      end else begin
         vb_prev_q <= vga_in_vblnk_i;
         done_q    <= 1'b0;
         if (clear_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (fe) vis_q <= 1'b0;
         end else begin
            case (state_q)
               IDLE, LANDED: begin
                  if (fe && state_q == IDLE) vis_q <= 1'b0;
                  if (start_i) begin
                     st_x_q  <= x_start_i;
                     st_y_q  <= y_start_i;
                     tgt_x_q <= x_end_i;
                     tgt_y_q <= y_end_i;
                     ang_q   <= angle_i;
                     busy_q  <= 1'b1;
                     state_q <= WAIT_FRAME;
                  end
               end
               WAIT_FRAME: begin
                  if (fe) begin
                     cur_x_q   <= st_x_q;
                     cur_y_q   <= st_y_q;
                     cur_ang_q <= ang_q;
                     vis_q     <= 1'b1;
                     state_q   <= MOVE;
                  end
               end
               MOVE: begin
                  if (fe) begin
                     if (cur_x_q == tgt_x_q && cur_y_q == tgt_y_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= LANDED;
                     end else begin
                        cur_x_q <= step_to(cur_x_q, tgt_x_q);
                        cur_y_q <= step_to(cur_y_q, tgt_y_q);
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   logic [12:0]       hc13, vc13, cx13, cy13, box_w, box_h;
   logic [11:0]       ix, iy;
   logic [ADDR_W-1:0] ixa, iya, addr_raw, addr_d;
   logic              inside_d;

   always_comb begin
      hc13  = {1'b0, vga_in_hcount_i};
      vc13  = {1'b0, vga_in_vcount_i};
      cx13  = {1'b0, cur_x_q};
      cy13  = {1'b0, cur_y_q};
      box_w = cur_ang_q[0] ? CH13 : CW13;
      box_h = cur_ang_q[0] ? CW13 : CH13;
      inside_d = vis_q && (hc13 >= cx13) && (hc13 < cx13 + box_w)
                       && (vc13 >= cy13) && (vc13 < cy13 + box_h);
      ix  = vga_in_hcount_i - cur_x_q;
      iy  = vga_in_vcount_i - cur_y_q;
      ixa = ADDR_W'(ix);
      iya = ADDR_W'(iy);
      case (cur_ang_q)
         2'd0:    addr_raw = iya * CWA + ixa;
         2'd1:    addr_raw = ixa * CWA + iya;
         2'd2:    addr_raw = (CHA - 1'b1 - iya) * CWA + (CWA - 1'b1 - ixa);
         default: addr_raw = (CHA - 1'b1 - ixa) * CWA + (CWA - 1'b1 - iya);
      endcase
      addr_d = inside_d ? addr_raw : '0;
   end

   // Timing fields packed as {hcount, vcount, hsync, vsync, hblnk, vblnk, rgb}.
   logic [39:0]       px_q [RL];
   logic              in_q [RL];
   logic [39:0]       out_q;
   logic [ADDR_W-1:0] pixel_addr_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pixel_addr_q <= '0;
         out_q        <= '0;
         for (int i = 0; i < RL; i++) begin
            px_q[i] <= '0;
            in_q[i] <= 1'b0;
         end
      end else begin
         pixel_addr_q <= addr_d;
         in_q[0]      <= inside_d;
         px_q[0]      <= {vga_in_hcount_i, vga_in_vcount_i, vga_in_hsync_i, vga_in_vsync_i,
                          vga_in_hblnk_i, vga_in_vblnk_i, vga_in_rgb_i};
         for (int i = 1; i < RL; i++) begin
            in_q[i] <= in_q[i-1];
            px_q[i] <= px_q[i-1];
         end
         // rgb_pixel now matches the address issued RL clocks ago.
         out_q[39:12] <= px_q[RL-1][39:12];
         out_q[11:0]  <= (in_q[RL-1] && rgb_pixel_i != KEY_RGB) ? rgb_pixel_i : px_q[RL-1][11:0];
      end
   end

   assign vga_out_hcount_o = out_q[39:28];
   assign vga_out_vcount_o = out_q[27:16];
   assign vga_out_hsync_o  = out_q[15];
   assign vga_out_vsync_o  = out_q[14];
   assign vga_out_hblnk_o  = out_q[13];
   assign vga_out_vblnk_o  = out_q[12];
   assign vga_out_rgb_o    = out_q[11:0];
   assign pixel_addr_o     = pixel_addr_q;
   assign busy_o           = busy_q;
   assign done_o           = done_q;

endmodule

// File: tb/tb_draw_card_mover.sv
// Directed bench for draw_card_mover: probe pixels are tagged with hsync=1 and their
// expected colour queued; a monitor pops and compares when tagged pixels come out.
module tb_draw_card_mover;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] hc, vc, bg;
   logic        hs, vs, hb, vb;
   logic [11:0] o_hc, o_vc, o_rgb;
   logic        o_hs, o_vs, o_hb, o_vb;
   logic        start, clear;
   logic [11:0] xs, ys, xe, ye;
   logic [1:0]  ang;
   logic [11:0] rgb_pixel;
   logic [12:0] pixel_addr;
   logic        busy, done;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      logic [11:0] rgb;
      logic [11:0] h;
      logic [11:0] v;
      int          issued;
   } exp_t;
   exp_t exp_q[$];

   draw_card_mover dut (
      .clk_i(clk), .rst_ni(rst_n),
      .vga_in_hcount_i(hc), .vga_in_vcount_i(vc), .vga_in_hsync_i(hs), .vga_in_vsync_i(vs),
      .vga_in_hblnk_i(hb), .vga_in_vblnk_i(vb), .vga_in_rgb_i(bg),
      .vga_out_hcount_o(o_hc), .vga_out_vcount_o(o_vc), .vga_out_hsync_o(o_hs),
      .vga_out_vsync_o(o_vs), .vga_out_hblnk_o(o_hb), .vga_out_vblnk_o(o_vb),
      .vga_out_rgb_o(o_rgb),
      .start_i(start), .x_start_i(xs), .y_start_i(ys), .x_end_i(xe), .y_end_i(ye),
      .angle_i(ang), .clear_i(clear), .rgb_pixel_i(rgb_pixel), .pixel_addr_o(pixel_addr),
      .busy_o(busy), .done_o(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // ROM contents: word 100 is the colour key, word 101 is pure red.
   function automatic logic [11:0] rom_fn(input logic [12:0] a);
      if (a == 13'd100) return 12'h0F0;
      if (a == 13'd101) return 12'hF00;
      return a[11:0] ^ 12'hA5A;
   endfunction

   assign rgb_pixel = rom_fn(pixel_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (o_hs) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_tagged_pixel", 32'(o_hc), 32'hFFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pixel_rgb", 32'(o_rgb), 32'(e.rgb));
            chk("pixel_hcount", 32'(o_hc), 32'(e.h));
            chk("pixel_vcount", 32'(o_vc), 32'(e.v));
            chk("latency", 32'(cyc - e.issued), 32'd2);
         end
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      hs = 1'b0; hc = '0; vc = '0;
      repeat (n) step();
   endtask

   // addr < 0 means the pixel lies outside the card box.
   task automatic probe(input int h, input int v, input int addr);
      exp_t e;
      hc = 12'(h); vc = 12'(v); bg = 12'h333; hs = 1'b1;
      e.h = hc; e.v = vc; e.issued = cyc;
      if (addr < 0) e.rgb = bg;
      else e.rgb = (rom_fn(13'(addr)) == 12'h0F0) ? bg : rom_fn(13'(addr));
      exp_q.push_back(e);
      step();
      hs = 1'b0;
   endtask

   task automatic fe_pulse(input logic exp_done, input string name);
      hs = 1'b0;
      vb = 1'b1;
      step();
      chk({name, "_done_at_fe"}, 32'(done), 32'(exp_done));
      step();
      chk({name, "_done_single"}, 32'(done), 32'd0);
      vb = 1'b0;
      step();
   endtask

   task automatic go(input int x0, input int y0, input int x1, input int y1, input int a);
      xs = 12'(x0); ys = 12'(y0); xe = 12'(x1); ye = 12'(y1); ang = 2'(a);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; clear = 1'b0;
      xs = '0; ys = '0; xe = '0; ye = '0; ang = '0;
      hc = 12'd5; vc = 12'd7; bg = 12'h333; hs = 1'b0; vs = 1'b1; hb = 1'b1; vb = 1'b0;
      repeat (3) step();
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_addr", 32'(pixel_addr), 32'd0);
      chk("reset_out_rgb", 32'(o_rgb), 32'd0);
      chk("reset_out_hcount", 32'(o_hc), 32'd0);
      chk("reset_out_vsync", 32'(o_vs), 32'd0);
      rst_n = 1'b1; vs = 1'b0; hb = 1'b0;
      idle(3);

      // Static draw at (100,50), angle 0
      go(100, 50, 100, 50, 0);
      probe(100, 50, -1);
      fe_pulse(1'b0, "static_load");
      probe(100, 50, 0);
      probe(155, 129, 4479);
      probe(156, 50, -1);
      probe(100, 130, -1);
      probe(99, 50, -1);
      probe(144, 51, 100);
      probe(145, 51, 101);
      fe_pulse(1'b1, "static_arrive");
      chk("busy_after_land", 32'(busy), 32'd0);
      probe(100, 50, 0);

      // Orientations at (200,200)
      go(200, 200, 200, 200, 1);
      fe_pulse(1'b0, "ang1_load");
      probe(279, 200, 4424);
      probe(200, 200, 0);
      probe(200, 255, 55);
      probe(200, 256, -1);
      probe(280, 200, -1);
      fe_pulse(1'b1, "ang1_arrive");
      go(200, 200, 200, 200, 2);
      fe_pulse(1'b0, "ang2_load");
      probe(200, 200, 4479);
      probe(255, 279, 0);
      fe_pulse(1'b1, "ang2_arrive");
      go(200, 200, 200, 200, 3);
      fe_pulse(1'b0, "ang3_load");
      probe(200, 200, 4479);
      probe(279, 200, 55);
      probe(279, 255, 0);
      fe_pulse(1'b1, "ang3_arrive");

      // Motion (0,0) -> (10,3)
      go(0, 0, 10, 3, 0);
      fe_pulse(1'b0, "mv_load");
      probe(0, 0, 0);
      fe_pulse(1'b0, "mv_step1");
      probe(4, 3, 0);
      probe(3, 3, -1);
      probe(4, 2, -1);
      fe_pulse(1'b0, "mv_step2");
      probe(8, 3, 0);
      probe(7, 3, -1);
      fe_pulse(1'b0, "mv_step3");
      probe(10, 3, 0);
      probe(9, 3, -1);
      fe_pulse(1'b1, "mv_arrive");
      fe_pulse(1'b0, "mv_hold");
      probe(10, 3, 0);

      // clear together with start during MOVE
      go(0, 0, 40, 0, 0);
      fe_pulse(1'b0, "clr_load");
      fe_pulse(1'b0, "clr_step");
      xs = 12'd300; ys = 12'd300; xe = 12'd300; ye = 12'd300;
      clear = 1'b1; start = 1'b1;
      step();
      clear = 1'b0; start = 1'b0;
      chk("busy_after_clear", 32'(busy), 32'd0);
      probe(4, 0, 0);
      fe_pulse(1'b0, "clr_fe1");
      probe(4, 0, -1);
      probe(300, 300, -1);
      fe_pulse(1'b0, "clr_fe2");
      chk("busy_idle_after_clear", 32'(busy), 32'd0);

      // Reset in the middle of a move
      go(0, 0, 40, 0, 0);
      fe_pulse(1'b0, "rst_load");
      fe_pulse(1'b0, "rst_step");
      idle(4);
      hc = 12'd5; vc = 12'd1; bg = 12'h333; vs = 1'b1;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1; vs = 1'b0;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_addr", 32'(pixel_addr), 32'd0);
      chk("midrst_out_rgb", 32'(o_rgb), 32'd0);
      chk("midrst_out_vsync", 32'(o_vs), 32'd0);
      probe(4, 0, -1);
      fe_pulse(1'b0, "midrst_fe1");
      probe(4, 0, -1);
      fe_pulse(1'b0, "midrst_fe2");
      chk("midrst_busy_later", 32'(busy), 32'd0);

      idle(6);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
